// File: rtl/mem_arbiter.sv
// Arbitrates the tagged unified memory port between instruction fetch and the LSU, tracking tag owners.
// Optional IF anti-starvation counter is enabled by defining MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    input  logic            lsu_req,
    input  logic [1:0]      lsu_cmd,
    input  logic [XLEN-1:0] lsu_addr,
    input  logic [63:0]     lsu_wdata,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic            if_gnt,
    output logic            lsu_gnt,
    output logic            if_rsp_valid,
    output logic [63:0]     if_rsp_data,
    output logic            lsu_rsp_valid,
    output logic [63:0]     lsu_rsp_data
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
        $error("mem_arbiter: STARVE_LIMIT must fit the 3-bit starvation counter (1..7)");
    end

    // Tag table, one bit per tag; index 0 is never allocated.
    logic [15:0] tag_valid_q, tag_valid_d;
    logic [15:0] tag_lsu_q,   tag_lsu_d;
    logic [15:0] tag_dead_q,  tag_dead_d;

    logic if_force;
    logic sel_lsu;
    logic sel_if;
    logic accept;
    logic alloc;
    logic rsp_hit;
    logic unused_if_addr_lsbs;

    assign unused_if_addr_lsbs = ^if_addr[2:0];

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = 3'd0;
        end else if (lsu_gnt) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    assign if_force = if_req && (starve_cnt_q == STARVE_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= 3'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign if_force = 1'b0;
`endif

    always_comb begin
        sel_lsu = lsu_req && (lsu_cmd != BUS_NONE) && !if_force;
        sel_if  = if_req && !sel_lsu;
        accept  = (mem2proc_response != 4'd0);
        rsp_hit = (mem2proc_tag != 4'd0) && tag_valid_q[mem2proc_tag] && !tag_dead_q[mem2proc_tag];
    end

    // Bus drive, grants and response routing; everything is forced quiet while reset is held.
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = 64'd0;
        if_gnt           = 1'b0;
        lsu_gnt          = 1'b0;
        if_rsp_valid     = 1'b0;
        if_rsp_data      = 64'd0;
        lsu_rsp_valid    = 1'b0;
        lsu_rsp_data     = 64'd0;
        if (reset) begin
            if (sel_lsu) begin
                proc2mem_command = lsu_cmd;
                proc2mem_addr    = lsu_addr;
                if (lsu_cmd == BUS_STORE) begin
                    proc2mem_data = lsu_wdata;
                end
                lsu_gnt = accept;
            end else if (sel_if) begin
                proc2mem_command = BUS_LOAD;
                proc2mem_addr    = {if_addr[XLEN-1:3], 3'b000};
                if_gnt           = accept;
            end

            if (rsp_hit) begin
                if (tag_lsu_q[mem2proc_tag]) begin
                    lsu_rsp_valid = 1'b1;
                    lsu_rsp_data  = mem2proc_data;
                end else if (!if_flush) begin
                    if_rsp_valid = 1'b1;
                    if_rsp_data  = mem2proc_data;
                end
            end
        end
    end

    // Free, then allocate (allocation wins on a tag clash), then kill IF entries on flush.
    always_comb begin
        tag_valid_d = tag_valid_q;
        tag_lsu_d   = tag_lsu_q;
        tag_dead_d  = tag_dead_q;
        alloc       = if_gnt || (lsu_gnt && (lsu_cmd == BUS_LOAD));

        if ((mem2proc_tag != 4'd0) && tag_valid_q[mem2proc_tag]) begin
            tag_valid_d[mem2proc_tag] = 1'b0;
            tag_dead_d[mem2proc_tag]  = 1'b0;
        end

        if (alloc) begin
            tag_valid_d[mem2proc_response] = 1'b1;
            tag_lsu_d[mem2proc_response]   = lsu_gnt;
            tag_dead_d[mem2proc_response]  = 1'b0;
        end

        if (if_flush) begin
            tag_dead_d = tag_dead_d | (tag_valid_d & ~tag_lsu_d);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid_q <= 16'd0;
            tag_lsu_q   <= 16'd0;
            tag_dead_q  <= 16'd0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_lsu_q   <= tag_lsu_d;
            tag_dead_q  <= tag_dead_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration, retries, tag routing, flush kills and reset.
module tb_mem_arbiter;

    localparam int XLEN = 32;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_flush;
    logic            lsu_req;
    logic [1:0]      lsu_cmd;
    logic [XLEN-1:0] lsu_addr;
    logic [63:0]     lsu_wdata;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic            if_gnt;
    logic            lsu_gnt;
    logic            if_rsp_valid;
    logic [63:0]     if_rsp_data;
    logic            lsu_rsp_valid;
    logic [63:0]     lsu_rsp_data;

    always #5 clock = ~clock;

    mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_flush         (if_flush),
        .lsu_req          (lsu_req),
        .lsu_cmd          (lsu_cmd),
        .lsu_addr         (lsu_addr),
        .lsu_wdata        (lsu_wdata),
        .mem2proc_response(mem2proc_response),
        .mem2proc_data    (mem2proc_data),
        .mem2proc_tag     (mem2proc_tag),
        .proc2mem_command (proc2mem_command),
        .proc2mem_addr    (proc2mem_addr),
        .proc2mem_data    (proc2mem_data),
        .if_gnt           (if_gnt),
        .lsu_gnt          (lsu_gnt),
        .if_rsp_valid     (if_rsp_valid),
        .if_rsp_data      (if_rsp_data),
        .lsu_rsp_valid    (lsu_rsp_valid),
        .lsu_rsp_data     (lsu_rsp_data)
    );

    typedef struct packed {
        logic        to_if;
        logic [63:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Pops the expected response (if any) and compares both response channels.
    task automatic check_rsp(input string tag);
        exp_t        e;
        logic        ev_if;
        logic        ev_lsu;
        logic [63:0] ed;
        ev_if  = 1'b0;
        ev_lsu = 1'b0;
        ed     = 64'd0;
        if (sb_q.size() > 0) begin
            e      = sb_q.pop_front();
            ev_if  = e.to_if;
            ev_lsu = !e.to_if;
            ed     = e.data;
        end
        chk({tag, ".if_rsp_valid"}, 64'(if_rsp_valid), 64'(ev_if));
        chk({tag, ".lsu_rsp_valid"}, 64'(lsu_rsp_valid), 64'(ev_lsu));
        if (ev_if) chk({tag, ".if_rsp_data"}, if_rsp_data, ed);
        if (ev_lsu) chk({tag, ".lsu_rsp_data"}, lsu_rsp_data, ed);
    endtask

    task automatic check_bus(input string tag, input logic [1:0] cmd, input logic [31:0] addr,
                             input logic [63:0] data, input logic ig, input logic lg);
        chk({tag, ".cmd"}, 64'(proc2mem_command), 64'(cmd));
        chk({tag, ".addr"}, 64'(proc2mem_addr), 64'(addr));
        chk({tag, ".data"}, proc2mem_data, data);
        chk({tag, ".if_gnt"}, 64'(if_gnt), 64'(ig));
        chk({tag, ".lsu_gnt"}, 64'(lsu_gnt), 64'(lg));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        if_req            = 1'b0;
        if_addr           = '0;
        if_flush          = 1'b0;
        lsu_req           = 1'b0;
        lsu_cmd           = BUS_NONE;
        lsu_addr          = '0;
        lsu_wdata         = 64'd0;
        mem2proc_response = 4'd0;
        mem2proc_data     = 64'd0;
        mem2proc_tag      = 4'd0;
    endtask

    task automatic ret(input logic [3:0] tag, input logic [63:0] data);
        mem2proc_tag  = tag;
        mem2proc_data = data;
    endtask

    initial begin
        logic exp_if;
        idle();
        // Reset held: requests present but everything must stay quiet.
        if_req = 1'b1; if_addr = 32'h1004;
        lsu_req = 1'b1; lsu_cmd = BUS_LOAD; lsu_addr = 32'h2000;
        mem2proc_response = 4'd3;
        #2;
        check_bus("reset_hold", BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0);
        check_rsp("reset_hold");
        tick();
        tick();
        idle();
        reset = 1'b1;
        tick();

        // IF only, fetch address aligned to 8 bytes.
        if_req = 1'b1; if_addr = 32'h1004; mem2proc_response = 4'd3;
        #1;
        check_bus("if_only", BUS_LOAD, 32'h1000, 64'h0, 1'b1, 1'b0);
        tick();
        idle();
        ret(4'd3, 64'hD1D1_0000_1111_0001);
        sb_q.push_back('{to_if: 1'b1, data: 64'hD1D1_0000_1111_0001});
        #1;
        check_rsp("if_ret3");
        tick();
        idle();
        ret(4'd3, 64'hBAD0);
        #1;
        check_rsp("tag3_freed");
        tick();

        // Both request: LSU wins, IF follows once LSU drops.
        idle();
        if_req = 1'b1; if_addr = 32'h2008;
        lsu_req = 1'b1; lsu_cmd = BUS_LOAD; lsu_addr = 32'h3004;
        mem2proc_response = 4'd5;
        #1;
        check_bus("both_lsu", BUS_LOAD, 32'h3004, 64'h0, 1'b0, 1'b1);
        tick();
        lsu_req = 1'b0; lsu_cmd = BUS_NONE; mem2proc_response = 4'd6;
        #1;
        check_bus("both_if", BUS_LOAD, 32'h2008, 64'h0, 1'b1, 1'b0);
        tick();
        idle();
        ret(4'd6, 64'hD2);
        sb_q.push_back('{to_if: 1'b1, data: 64'hD2});
        #1;
        check_rsp("ret6_if");
        tick();
        ret(4'd5, 64'hD3);
        sb_q.push_back('{to_if: 1'b0, data: 64'hD3});
        #1;
        check_rsp("ret5_lsu");
        tick();

        // Rejected three times, then accepted with tag 2.
        idle();
        if_req = 1'b1; if_addr = 32'h4010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_bus("retry", BUS_LOAD, 32'h4010, 64'h0, 1'b0, 1'b0);
            tick();
        end
        mem2proc_response = 4'd2;
        #1;
        check_bus("retry_acc", BUS_LOAD, 32'h4010, 64'h0, 1'b1, 1'b0);
        tick();
        idle();
        ret(4'd2, 64'hD7);
        sb_q.push_back('{to_if: 1'b1, data: 64'hD7});
        #1;
        check_rsp("ret2_if");
        tick();

        // Store: granted, no table entry.
        idle();
        lsu_req = 1'b1; lsu_cmd = BUS_STORE; lsu_addr = 32'h5004;
        lsu_wdata = 64'hCAFE_F00D_1234_5678; mem2proc_response = 4'd4;
        #1;
        check_bus("store", BUS_STORE, 32'h5004, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b1);
        tick();
        idle();
        ret(4'd4, 64'hD4);
        #1;
        check_rsp("store_ret4");
        tick();

        // Flush kills fetch tag 7; LSU tag 10 survives; tag 9 granted during flush also dies.
        idle();
        if_req = 1'b1; if_addr = 32'h6000; mem2proc_response = 4'd7;
        tick();
        idle();
        lsu_req = 1'b1; lsu_cmd = BUS_LOAD; lsu_addr = 32'h6100; mem2proc_response = 4'd10;
        tick();
        idle();
        if_req = 1'b1; if_addr = 32'h6200; mem2proc_response = 4'd9; if_flush = 1'b1;
        #1;
        check_bus("flush_gnt", BUS_LOAD, 32'h6200, 64'h0, 1'b1, 1'b0);
        tick();
        idle();
        ret(4'd7, 64'hD5);
        #1;
        check_rsp("flushed7");
        tick();
        ret(4'd9, 64'hD9);
        #1;
        check_rsp("flushed9");
        tick();
        ret(4'd10, 64'hDA);
        sb_q.push_back('{to_if: 1'b0, data: 64'hDA});
        #1;
        check_rsp("lsu10_survives");
        tick();
        idle();
        if_req = 1'b1; if_addr = 32'h6300; mem2proc_response = 4'd7;
        tick();
        idle();
        ret(4'd7, 64'hD6);
        sb_q.push_back('{to_if: 1'b1, data: 64'hD6});
        #1;
        check_rsp("tag7_reuse");
        tick();

        // IF response arriving in the flush cycle is suppressed.
        idle();
        if_req = 1'b1; if_addr = 32'h6400; mem2proc_response = 4'd8;
        tick();
        idle();
        if_flush = 1'b1;
        ret(4'd8, 64'hD8);
        #1;
        check_rsp("flush_cycle8");
        tick();

        // Same tag freed and reallocated in one cycle.
        idle();
        if_req = 1'b1; if_addr = 32'h7000; mem2proc_response = 4'd11;
        tick();
        idle();
        lsu_req = 1'b1; lsu_cmd = BUS_LOAD; lsu_addr = 32'h7100; mem2proc_response = 4'd11;
        ret(4'd11, 64'hE1);
        sb_q.push_back('{to_if: 1'b1, data: 64'hE1});
        #1;
        check_rsp("clash_old_owner");
        chk("clash.lsu_gnt", 64'(lsu_gnt), 64'd1);
        tick();
        idle();
        ret(4'd11, 64'hE2);
        sb_q.push_back('{to_if: 1'b0, data: 64'hE2});
        #1;
        check_rsp("clash_new_owner");
        tick();

        // Outstanding fetch tag 13, to be discarded by the reset below.
        idle();
        if_req = 1'b1; if_addr = 32'h8000; mem2proc_response = 4'd13;
        tick();

        // Both requesting continuously.
        idle();
        if_req = 1'b1; if_addr = 32'h9000;
        lsu_req = 1'b1; lsu_cmd = BUS_STORE; lsu_addr = 32'h9100; lsu_wdata = 64'h55;
        mem2proc_response = 4'd12;
        for (int i = 0; i < 10; i++) begin
            #1;
`ifdef MEM_ARB_FAIRNESS_EN
            exp_if = (i % 5 == 4);
`else
            exp_if = 1'b0;
`endif
            chk($sformatf("pat%0d.if_gnt", i), 64'(if_gnt), 64'(exp_if));
            chk($sformatf("pat%0d.lsu_gnt", i), 64'(lsu_gnt), 64'(!exp_if));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        reset = 1'b0;
        ret(4'd13, 64'hF1);
        #1;
        check_bus("mid_reset", BUS_NONE, 32'h0, 64'h0, 1'b0, 1'b0);
        check_rsp("mid_reset");
        tick();
        reset = 1'b1;
        mem2proc_tag = 4'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
`ifdef MEM_ARB_FAIRNESS_EN
            exp_if = (i == 4);
`else
            exp_if = 1'b0;
`endif
            chk($sformatf("post%0d.if_gnt", i), 64'(if_gnt), 64'(exp_if));
            chk($sformatf("post%0d.lsu_gnt", i), 64'(lsu_gnt), 64'(!exp_if));
            tick();
        end
        idle();
        ret(4'd13, 64'hF2);
        #1;
        check_rsp("tag13_discarded");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
